ceespu_branch_resolver: RTL and testbench

- Resolution-side partner of the gshare branch predictor. Records every predicted branch at fetch in an in-order queue of in-flight predictions.
- When execute resolves the oldest branch, it compares the real outcome against the recorded prediction and produces two things: the predictor update interface (update_table, branch_address, branch_prediction_state, branch_taken) and a mispredict flush/redirect to fetch.
- Sits between fetch/predictor and the execute-stage branch unit.

---
 rtl/ceespu_branch_resolver.sv | 172 +++++++++++++++++
 tb/tb_ceespu_branch_resolver.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ceespu_branch_resolver.sv
// In-order queue of predicted branches. Compares each resolved branch with its
// recorded prediction, drives the gshare table update and the fetch redirect.
module ceespu_branch_resolver #(
    parameter int DEPTH_LOG2 = 2,
    parameter int PC_W       = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  I_push,
    input  logic [PC_W-1:0]       I_push_pc,
    input  logic [1:0]            I_push_state,
    input  logic                  I_push_taken,
    input  logic [PC_W-1:0]       I_push_target,
    input  logic                  I_resolve,
    input  logic                  I_actual_taken,
    input  logic [PC_W-1:0]       I_actual_target,
    input  logic                  I_flush,
    output logic                  O_full,
    output logic                  O_empty,
    output logic [DEPTH_LOG2:0]   O_count,
    output logic                  O_update_table,
    output logic [PC_W-1:0]       O_branch_address,
    output logic [1:0]            O_branch_prediction_state,
    output logic                  O_branch_taken,
    output logic                  O_mispredict,
    output logic [PC_W-1:0]       O_redirect_pc,
    output logic                  O_error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [PC_W-1:0]       PC_ONE   = 1;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [1:0]      state;
        logic            taken;
        logic [PC_W-1:0] target;
    } entry_t;

    entry_t                mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  update_q, update_d;
    logic                  mispredict_q, mispredict_d;
    logic                  error_q, error_d;
    logic [PC_W-1:0]       addr_q, addr_d;
    logic [1:0]            state_q, state_d;
    logic                  taken_q, taken_d;
    logic [PC_W-1:0]       redirect_q, redirect_d;

    entry_t          head;
    entry_t          push_entry;
    logic            full, empty;
    logic            resolve_ok, push_ok, mispredict_c, write_en;
    logic [PC_W-1:0] redirect_c;

    assign head       = mem_q[rp_q];
    assign push_entry = '{pc: I_push_pc, state: I_push_state,
                          taken: I_push_taken, target: I_push_target};

    assign full       = (count_q == CNT_FULL);
    assign empty      = (count_q == '0);
    assign resolve_ok = I_resolve && !empty;
    // A resolve frees the head slot this cycle, so a full queue can still take a push.
    assign push_ok    = I_push && (!full || resolve_ok);

    assign mispredict_c = resolve_ok &&
                          ((I_actual_taken != head.taken) ||
                           (I_actual_taken && (I_actual_target != head.target)));
    assign redirect_c   = I_actual_taken ? I_actual_target : head.pc + PC_ONE;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        wp_d         = wp_q;
        rp_d         = rp_q;
        count_d      = count_q;
        write_en     = 1'b0;
        update_d     = 1'b0;
        mispredict_d = 1'b0;
        error_d      = error_q;
        addr_d       = addr_q;
        state_d      = state_q;
        taken_d      = taken_q;
        redirect_d   = redirect_q;

        if (I_flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if ((I_push && !push_ok) || (I_resolve && empty)) begin
                error_d = 1'b1;
            end
            if (resolve_ok) begin
                update_d     = 1'b1;
                mispredict_d = mispredict_c;
                addr_d       = head.pc;
                state_d      = head.state;
                taken_d      = I_actual_taken;
                redirect_d   = redirect_c;
            end
            // Everything younger than a mispredicted branch is wrong-path.
            if (mispredict_c) begin
                wp_d    = '0;
                rp_d    = '0;
                count_d = '0;
            end else begin
                if (push_ok) begin
                    write_en = 1'b1;
                    wp_d     = wp_q + PTR_ONE;
                end
                if (resolve_ok) begin
                    rp_d = rp_q + PTR_ONE;
                end
                case ({push_ok, resolve_ok})
                    2'b10:   count_d = count_q + CNT_ONE;
                    2'b01:   count_d = count_q - CNT_ONE;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q         <= '0;
            rp_q         <= '0;
            count_q      <= '0;
            update_q     <= 1'b0;
            mispredict_q <= 1'b0;
            error_q      <= 1'b0;
            addr_q       <= '0;
            state_q      <= '0;
            taken_q      <= 1'b0;
            redirect_q   <= '0;
        end else begin
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            count_q      <= count_d;
            update_q     <= update_d;
            mispredict_q <= mispredict_d;
            error_q      <= error_d;
            addr_q       <= addr_d;
            state_q      <= state_d;
            taken_q      <= taken_d;
            redirect_q   <= redirect_d;
        end
    end

    // NOTE: queue storage is not reset; count/pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[wp_q] <= push_entry;
        end
    end

    assign O_full                    = full;
    assign O_empty                   = empty;
    assign O_count                   = count_q;
    assign O_update_table            = update_q;
    assign O_branch_address          = addr_q;
    assign O_branch_prediction_state = state_q;
    assign O_branch_taken            = taken_q;
    assign O_mispredict              = mispredict_q;
    assign O_redirect_pc             = redirect_q;
    assign O_error                   = error_q;

endmodule

// File: tb/tb_ceespu_branch_resolver.sv
// Directed vector bench for ceespu_branch_resolver: a table of one-cycle
// vectors with hand-computed results, then a push/resolve wrap sequence.
module tb_ceespu_branch_resolver;

    localparam int PC_W = 14;

    typedef struct {
        logic            rst;
        logic            push;
        logic [PC_W-1:0] pc;
        logic [1:0]      st;
        logic            tk;
        logic [PC_W-1:0] tgt;
        logic            res;
        logic            atk;
        logic [PC_W-1:0] atgt;
        logic            fl;
        logic            upd;
        logic [PC_W-1:0] addr;
        logic [1:0]      est;
        logic            btk;
        logic            mis;
        logic [PC_W-1:0] rpc;
        int              cnt;
        logic            err;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            I_push = 1'b0;
    logic [PC_W-1:0] I_push_pc = '0;
    logic [1:0]      I_push_state = '0;
    logic            I_push_taken = 1'b0;
    logic [PC_W-1:0] I_push_target = '0;
    logic            I_resolve = 1'b0;
    logic            I_actual_taken = 1'b0;
    logic [PC_W-1:0] I_actual_target = '0;
    logic            I_flush = 1'b0;
    logic            O_full, O_empty;
    logic [2:0]      O_count;
    logic            O_update_table;
    logic [PC_W-1:0] O_branch_address;
    logic [1:0]      O_branch_prediction_state;
    logic            O_branch_taken;
    logic            O_mispredict;
    logic [PC_W-1:0] O_redirect_pc;
    logic            O_error;

    int n_vec  = 0;
    int n_chk  = 0;
    int n_miss = 0;

    // Expected values of the held data outputs.
    logic [PC_W-1:0] h_addr = '0;
    logic [1:0]      h_st   = '0;
    logic            h_btk  = 1'b0;
    logic [PC_W-1:0] h_rpc  = '0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    ceespu_branch_resolver #(.DEPTH_LOG2(2), .PC_W(PC_W)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .I_push                    (I_push),
        .I_push_pc                 (I_push_pc),
        .I_push_state              (I_push_state),
        .I_push_taken              (I_push_taken),
        .I_push_target             (I_push_target),
        .I_resolve                 (I_resolve),
        .I_actual_taken            (I_actual_taken),
        .I_actual_target           (I_actual_target),
        .I_flush                   (I_flush),
        .O_full                    (O_full),
        .O_empty                   (O_empty),
        .O_count                   (O_count),
        .O_update_table            (O_update_table),
        .O_branch_address          (O_branch_address),
        .O_branch_prediction_state (O_branch_prediction_state),
        .O_branch_taken            (O_branch_taken),
        .O_mispredict              (O_mispredict),
        .O_redirect_pc             (O_redirect_pc),
        .O_error                   (O_error)
    );

    function automatic vec_t mk(
        input logic rst_v, input logic push_v, input logic [PC_W-1:0] pc_v, input logic [1:0] st_v,
        input logic tk_v, input logic [PC_W-1:0] tgt_v,
        input logic res_v, input logic atk_v, input logic [PC_W-1:0] atgt_v, input logic fl_v,
        input logic upd_v, input logic [PC_W-1:0] addr_v, input logic [1:0] est_v, input logic btk_v,
        input logic mis_v, input logic [PC_W-1:0] rpc_v, input int cnt_v, input logic err_v);
        vec_t v;
        v.rst = rst_v; v.push = push_v; v.pc = pc_v; v.st = st_v; v.tk = tk_v; v.tgt = tgt_v;
        v.res = res_v; v.atk = atk_v; v.atgt = atgt_v; v.fl = fl_v;
        v.upd = upd_v; v.addr = addr_v; v.est = est_v; v.btk = btk_v; v.mis = mis_v; v.rpc = rpc_v;
        v.cnt = cnt_v; v.err = err_v;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector, clock once, compare all outputs #1 after the edge.
    task automatic run_vec(input vec_t v, input string tag);
        rst             = v.rst;
        I_push          = v.push;
        I_push_pc       = v.pc;
        I_push_state    = v.st;
        I_push_taken    = v.tk;
        I_push_target   = v.tgt;
        I_resolve       = v.res;
        I_actual_taken  = v.atk;
        I_actual_target = v.atgt;
        I_flush         = v.fl;
        @(posedge clk);
        #1;
        if (v.rst) begin
            h_addr = '0; h_st = '0; h_btk = 1'b0; h_rpc = '0;
        end else if (v.upd) begin
            h_addr = v.addr; h_st = v.est; h_btk = v.btk; h_rpc = v.rpc;
        end
        n_vec++;
        check({tag, " update_table"}, 32'(O_update_table), 32'(v.upd));
        check({tag, " mispredict"},   32'(O_mispredict),   32'(v.mis));
        check({tag, " branch_addr"},  32'(O_branch_address), 32'(h_addr));
        check({tag, " pred_state"},   32'(O_branch_prediction_state), 32'(h_st));
        check({tag, " branch_taken"}, 32'(O_branch_taken), 32'(h_btk));
        check({tag, " redirect_pc"},  32'(O_redirect_pc),  32'(h_rpc));
        check({tag, " count"},        32'(O_count),        32'(v.cnt));
        check({tag, " full"},         32'(O_full),         32'(v.cnt == 4));
        check({tag, " empty"},        32'(O_empty),        32'(v.cnt == 0));
        check({tag, " error"},        32'(O_error),        32'(v.err));
    endtask

    initial begin
        //              rst push pc      st tk tgt      res atk atgt     fl  upd addr     est btk mis rpc      cnt err
        tbl.push_back(mk(1, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 0, 0));
        // correct taken branch, then pulse drops
        tbl.push_back(mk(0, 1, 14'h0010, 2, 1, 14'h0040, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 1, 14'h0040, 0, 1, 14'h0010, 2, 1, 0, 14'h0040, 0, 0));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 0, 0));
        // predicted not-taken, actually taken
        tbl.push_back(mk(0, 1, 14'h0020, 1, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 1, 14'h0100, 0, 1, 14'h0020, 1, 1, 1, 14'h0100, 0, 0));
        // predicted taken at top of PC space, actually not taken: fall-through wraps to 0
        tbl.push_back(mk(0, 1, 14'h3FFF, 3, 1, 14'h0005, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 0, 14'h1234, 0, 1, 14'h3FFF, 3, 0, 1, 14'h0000, 0, 0));
        // right direction, wrong target
        tbl.push_back(mk(0, 1, 14'h0030, 3, 1, 14'h0050, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 1, 14'h0060, 0, 1, 14'h0030, 3, 1, 1, 14'h0060, 0, 0));
        // correct not-taken: target compare ignored
        tbl.push_back(mk(0, 1, 14'h0031, 0, 0, 14'h0077, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 1, 0));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 0, 14'h0099, 0, 1, 14'h0031, 0, 0, 0, 14'h0032, 0, 0));
        // A,B,C queued; A mispredicts while D is pushed
        tbl.push_back(mk(0, 1, 14'h0040, 1, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 1, 0));
        tbl.push_back(mk(0, 1, 14'h0041, 2, 1, 14'h0080, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 2, 0));
        tbl.push_back(mk(0, 1, 14'h0042, 3, 1, 14'h0090, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 3, 0));
        tbl.push_back(mk(0, 1, 14'h0043, 0, 1, 14'h0099, 1, 1, 14'h0044, 0, 1, 14'h0040, 1, 1, 1, 14'h0044, 0, 0));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 1, 14'h0044, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 0, 1));
        tbl.push_back(mk(0, 1, 14'h0050, 2, 1, 14'h0060, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 1, 1));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 1, 14'h0060, 0, 1, 14'h0050, 2, 1, 0, 14'h0060, 0, 1));
        // reset with three entries queued and a resolve pending
        tbl.push_back(mk(0, 1, 14'h0070, 1, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 1, 1));
        tbl.push_back(mk(0, 1, 14'h0071, 1, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 2, 1));
        tbl.push_back(mk(0, 1, 14'h0072, 1, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 3, 1));
        tbl.push_back(mk(1, 1, 14'h0073, 1, 0, 14'h0000, 1, 1, 14'h0005, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 0, 0));
        // fill, drop a push, overlap push with correct resolve, drain
        tbl.push_back(mk(0, 1, 14'h0100, 2, 1, 14'h0200, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 1, 0));
        tbl.push_back(mk(0, 1, 14'h0101, 1, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 2, 0));
        tbl.push_back(mk(0, 1, 14'h0102, 2, 1, 14'h0210, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 3, 0));
        tbl.push_back(mk(0, 1, 14'h0103, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 4, 0));
        tbl.push_back(mk(0, 1, 14'h0104, 1, 1, 14'h0111, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 4, 1));
        tbl.push_back(mk(0, 1, 14'h0105, 3, 1, 14'h0300, 1, 1, 14'h0200, 0, 1, 14'h0100, 2, 1, 0, 14'h0200, 4, 1));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 0, 14'h0000, 0, 1, 14'h0101, 1, 0, 0, 14'h0102, 3, 1));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 1, 14'h0210, 0, 1, 14'h0102, 2, 1, 0, 14'h0210, 2, 1));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 0, 14'h0000, 0, 1, 14'h0103, 0, 0, 0, 14'h0104, 1, 1));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 1, 14'h0300, 0, 1, 14'h0105, 3, 1, 0, 14'h0300, 0, 1));
        // flush beats resolve and push; error stays set
        tbl.push_back(mk(0, 1, 14'h0080, 2, 1, 14'h0090, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 1, 1));
        tbl.push_back(mk(0, 1, 14'h0081, 1, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 2, 1));
        tbl.push_back(mk(0, 1, 14'h0082, 1, 0, 14'h0000, 1, 0, 14'h0000, 1, 0, 14'h0000, 0, 0, 0, 14'h0000, 0, 1));
        tbl.push_back(mk(0, 1, 14'h0088, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 14'h0000, 1, 1));
        tbl.push_back(mk(0, 0, 14'h0000, 0, 0, 14'h0000, 1, 0, 14'h0000, 0, 1, 14'h0088, 0, 0, 0, 14'h0089, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("row%0d", i));
        end

        // Push/resolve pairs; every fourth branch mispredicts, the rest are correct.
        for (int i = 0; i < 10; i++) begin
            vec_t v;
            logic            tk, atk, mis;
            logic [PC_W-1:0] pc, tgt;
            pc  = PC_W'(14'h0200 + i);
            tgt = PC_W'(14'h0300 + i);
            tk  = i[0];
            mis = ((i % 4) == 3);
            atk = mis ? !tk : tk;
            v = mk(0, 1, pc, 2'(i % 4), tk, tgt, 0, 0, '0, 0, 0, '0, 0, 0, 0, '0, 1, 1);
            run_vec(v, $sformatf("wrap%0d_push", i));
            v = mk(0, 0, '0, 0, 0, '0, 1, atk, tgt, 0,
                   1, pc, 2'(i % 4), atk, mis, atk ? tgt : pc + 14'h0001, 0, 1);
            run_vec(v, $sformatf("wrap%0d_resolve", i));
        end

        rst = 1'b0; I_push = 1'b0; I_resolve = 1'b0; I_flush = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
